// File: rtl/ibex_cx_fabric_ctrl.sv
// ibex_cx_fabric_ctrl: dispatches CX custom instructions from the EX stage
// to one of NUM_CH eFPGA fabric channels. The unit issues over a req/ack
// handshake and completes either after a fixed delay or on a fabric valid.
// A watchdog, a pipeline kill and an error flag are included. EX sees
// ready_o low while an operation is busy and a one-cycle ready pulse when
// the result is available.
// Optional build macro IBEX_CX_PERF_CNT_EN adds saturating performance
// counters: completed operations and busy cycles, with a synchronous clear.
module ibex_cx_fabric_ctrl #(
  parameter int NUM_CH  = 4,
  parameter int DATA_W  = 32,
  parameter int OP_W    = 2,
  parameter int DLY_W   = 4,
  parameter int TIMEOUT = 255,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en_i,
  input  logic                     kill_i,
  input  logic [CH_W-1:0]          chan_i,
  input  logic [OP_W-1:0]          op_i,
  input  logic [DATA_W-1:0]        operand_a_i,
  input  logic [DATA_W-1:0]        operand_b_i,
  input  logic [DLY_W-1:0]         delay_i,
  output logic                     ready_o,
  output logic [DATA_W-1:0]        result_o,
  output logic                     err_o,
  output logic [NUM_CH-1:0]        fab_req_o,
  output logic [OP_W-1:0]          fab_op_o,
  output logic [DATA_W-1:0]        fab_a_o,
  output logic [DATA_W-1:0]        fab_b_o,
  input  logic [NUM_CH-1:0]        fab_ack_i,
  input  logic [NUM_CH-1:0]        fab_valid_i,
  input  logic [NUM_CH*DATA_W-1:0] fab_result_i
`ifdef IBEX_CX_PERF_CNT_EN
  ,
  input  logic                     perf_clr_i,
  output logic [31:0]              perf_ops_o,
  output logic [31:0]              perf_busy_o
`endif
);

  // The watchdog only needs to count up to TIMEOUT-1: expiry is detected in
  // the TIMEOUT-th busy cycle, before the counter would move past that value.
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LIM = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  // The channel count is widened by one bit so that NUM_CH is representable
  // when it is a power of two.
  localparam logic [CH_W:0] NUM_CH_L = NUM_CH[CH_W:0];

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_reg, state_next;
  logic [CH_W-1:0]    chan_reg;
  logic [DLY_W-1:0]   dly_reg;
  logic [DLY_W-1:0]   cnt_reg;
  logic [WD_W-1:0]    wd_reg;
  logic [OP_W-1:0]    op_reg;
  logic [DATA_W-1:0]  a_reg;
  logic [DATA_W-1:0]  b_reg;
  logic [DATA_W-1:0]  result_reg;
  logic               err_reg;

  logic               chan_ok;
  logic               ack_hit;
  logic               valid_hit;
  logic               wd_expire;
  logic               op_done;
  logic [DATA_W-1:0]  ch_result [NUM_CH];
  logic [DATA_W-1:0]  sel_result;

  // Split the flat fabric result bus into one word per channel, and decode
  // the one-hot issue request from the latched channel.
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
      assign ch_result[gi] = fab_result_i[gi*DATA_W +: DATA_W];
      assign fab_req_o[gi] = (state_reg == ISSUE) && (chan_reg == CH_W'(gi));
    end
  endgenerate

  assign chan_ok    = ({1'b0, chan_i} < NUM_CH_L);
  assign ack_hit    = fab_ack_i[chan_reg];
  assign valid_hit  = fab_valid_i[chan_reg];
  assign sel_result = ch_result[chan_reg];
  assign wd_expire  = (TIMEOUT != 0) && (wd_reg == WD_LIM);
  // Delay mode completes when the countdown reads 1; handshake mode
  // completes on the selected channel's valid.
  assign op_done    = (dly_reg != '0) ? (cnt_reg == DLY_W'(1)) : valid_hit;

  assign ready_o  = ((state_reg == IDLE) && !en_i) || (state_reg == DONE);
  assign result_o = result_reg;
  assign err_o    = err_reg;
  assign fab_op_o = op_reg;
  assign fab_a_o  = a_reg;
  assign fab_b_o  = b_reg;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; the watchdog beats ack/valid, and kill beats everything.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (en_i) begin
          state_next = chan_ok ? ISSUE : DONE;
        end
      end
      ISSUE: begin
        if (wd_expire) begin
          state_next = DONE;
        end else if (ack_hit) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (wd_expire || op_done) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (kill_i) begin
      state_next = IDLE;
    end
  end

  // Operand latching, countdown, watchdog and result/error capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chan_reg   <= '0;
      dly_reg    <= '0;
      cnt_reg    <= '0;
      wd_reg     <= '0;
      op_reg     <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      result_reg <= '0;
      err_reg    <= 1'b0;
    end else if (kill_i) begin
      err_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (en_i && chan_ok) begin
            chan_reg <= chan_i;
            op_reg   <= op_i;
            a_reg    <= operand_a_i;
            b_reg    <= operand_b_i;
            dly_reg  <= delay_i;
            wd_reg   <= '0;
            err_reg  <= 1'b0;
          end else if (en_i) begin
            result_reg <= '0;
            err_reg    <= 1'b1;
          end
        end
        ISSUE: begin
          wd_reg <= wd_reg + WD_W'(1);
          if (wd_expire) begin
            result_reg <= '1;
            err_reg    <= 1'b1;
          end else if (ack_hit) begin
            cnt_reg <= dly_reg;
          end
        end
        WAIT: begin
          wd_reg <= wd_reg + WD_W'(1);
          if (dly_reg != '0) begin
            cnt_reg <= cnt_reg - DLY_W'(1);
          end
          if (wd_expire) begin
            result_reg <= '1;
            err_reg    <= 1'b1;
          end else if (op_done) begin
            result_reg <= sel_result;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef IBEX_CX_PERF_CNT_EN
  logic [31:0] perf_ops_reg;
  logic [31:0] perf_busy_reg;

  // Saturating counters for error-free completions and busy cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_ops_reg  <= '0;
      perf_busy_reg <= '0;
    end else if (perf_clr_i) begin
      perf_ops_reg  <= '0;
      perf_busy_reg <= '0;
    end else begin
      if ((state_reg == DONE) && !err_reg && (perf_ops_reg != '1)) begin
        perf_ops_reg <= perf_ops_reg + 32'd1;
      end
      if (((state_reg == ISSUE) || (state_reg == WAIT)) && (perf_busy_reg != '1)) begin
        perf_busy_reg <= perf_busy_reg + 32'd1;
      end
    end
  end

  assign perf_ops_o  = perf_ops_reg;
  assign perf_busy_o = perf_busy_reg;
`endif

endmodule
